// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle terminator: per-device wait states to /DTACK, DUART /DTACK pass-through.
// Optional BUS_WATCHDOG_EN builds the /BERR watchdog; without it berr is tied inactive.
module bus_cycle_ctrl #(
    parameter int ROM_WAIT     = 2,
    parameter int RAM_WAIT     = 0,
    parameter int BERR_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic clk_in,
    input  logic reset,
    input  logic as,
    input  logic rom_sel,
    input  logic ram_sel,
    input  logic duart_sel,
    input  logic duart_dtack,
    output logic dtack,
    output logic berr,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DUART = 3'd2,
        ST_NOSEL = 3'd3,
        ST_ACK   = 3'd4,
        ST_BERR  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] ROM_LOAD_C = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_LOAD_C = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             dtack_r;
    logic             busy_r;
    logic             dtack_next_s;
    logic             busy_next_s;

`ifdef BUS_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST_C = CNT_W'(BERR_TIMEOUT - 1);

    logic [CNT_W-1:0] wd_r;
    logic [CNT_W-1:0] wd_next_s;
    logic             timeout_s;
    logic             berr_r;
    logic             berr_next_s;
`else
    localparam int wd_unused_cfg = BERR_TIMEOUT;
`endif

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            dtack_r <= 1'b1;
            busy_r  <= 1'b0;
`ifdef BUS_WATCHDOG_EN
            wd_r    <= {CNT_W{1'b0}};
            berr_r  <= 1'b1;
`endif
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            dtack_r <= dtack_next_s;
            busy_r  <= busy_next_s;
`ifdef BUS_WATCHDOG_EN
            wd_r    <= wd_next_s;
            berr_r  <= berr_next_s;
`endif
        end
    end

    // Next-state and counter update; /AS release always aborts, ack beats timeout
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
`ifdef BUS_WATCHDOG_EN
        wd_next_s    = wd_r;
        timeout_s    = (wd_r == WD_LAST_C);
`endif
        case (state_r)
            ST_IDLE: begin
                if (!as) begin
`ifdef BUS_WATCHDOG_EN
                    wd_next_s = {CNT_W{1'b0}};
`endif
                    if (rom_sel) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = ROM_LOAD_C;
                    end else if (ram_sel) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = RAM_LOAD_C;
                    end else if (duart_sel) begin
                        state_next_s = ST_DUART;
                    end else begin
                        state_next_s = ST_NOSEL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (as) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_ACK;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE_C;
`ifdef BUS_WATCHDOG_EN
                    if (timeout_s) begin
                        state_next_s = ST_BERR;
                    end else begin
                        wd_next_s = wd_r + CNT_ONE_C;
                    end
`endif
                end
            end
            ST_DUART: begin
                if (as) begin
                    state_next_s = ST_IDLE;
                end else if (!duart_dtack) begin
                    state_next_s = ST_ACK;
                end else begin
`ifdef BUS_WATCHDOG_EN
                    if (timeout_s) begin
                        state_next_s = ST_BERR;
                    end else begin
                        wd_next_s = wd_r + CNT_ONE_C;
                    end
`else
                    state_next_s = ST_DUART;
`endif
                end
            end
            ST_NOSEL: begin
                if (as) begin
                    state_next_s = ST_IDLE;
                end else begin
`ifdef BUS_WATCHDOG_EN
                    if (timeout_s) begin
                        state_next_s = ST_BERR;
                    end else begin
                        wd_next_s = wd_r + CNT_ONE_C;
                    end
`else
                    state_next_s = ST_NOSEL;
`endif
                end
            end
            ST_ACK, ST_BERR: begin
                if (as) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the strobes are registered with it
    always_comb begin
        dtack_next_s = (state_next_s != ST_ACK);
        busy_next_s  = (state_next_s != ST_IDLE);
`ifdef BUS_WATCHDOG_EN
        berr_next_s  = (state_next_s != ST_BERR);
`endif
    end

    assign dtack = dtack_r;
    assign busy  = busy_r;
`ifdef BUS_WATCHDOG_EN
    assign berr  = berr_r;
`else
    assign berr  = 1'b1;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: directed cycles plus random cycles against an offset-based model.
// Expectations follow BUS_WATCHDOG_EN the same way the design does.
module tb_bus_cycle_ctrl;

    localparam int ROM_W = 2;
    localparam int RAM_W = 0;
    localparam int T_OUT = 64;
    localparam int CW    = 7;
    localparam int INF   = 1000000;
`ifdef BUS_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic reset, as, rom_sel, ram_sel, duart_sel, duart_dtack;
    logic dtack, berr, busy;
    int   total  = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk_in = ~clk_in;

    bus_cycle_ctrl #(
        .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .BERR_TIMEOUT(T_OUT), .CNT_W(CW)
    ) dut (
        .clk_in(clk_in), .reset(reset), .as(as), .rom_sel(rom_sel), .ram_sel(ram_sel),
        .duart_sel(duart_sel), .duart_dtack(duart_dtack),
        .dtack(dtack), .berr(berr), .busy(busy)
    );

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "time limit");
    end

    task automatic chk(input logic obs, input logic exp, input string tag);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic e_dtack, input logic e_berr, input logic e_busy);
        chk(dtack, e_dtack, {tag, ".dtack"});
        chk(berr,  e_berr,  {tag, ".berr"});
        chk(busy,  e_busy,  {tag, ".busy"});
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        as = 1'b1; rom_sel = 1'b0; ram_sel = 1'b0; duart_sel = 1'b0; duart_dtack = 1'b1;
        for (int i = 0; i < n; i++) begin
            step;
            chk3($sformatf("%s.idle%0d", tag, i), 1'b1, 1'b1, 1'b0);
        end
    endtask

    // One bus cycle; the model works in edge offsets k from the start edge N.
    task automatic run_cycle(input logic r, input logic m, input logic d, input int dly,
                             input int abort_a, input int hold, input string tag);
        int ack_k, berr_k, term_k, end_k, a;
        bit term_ack, aborted, is_duart;
        logic e_d, e_b;
        is_duart = !r && !m && d;
        ack_k  = r ? 1 + ROM_W : (m ? 1 + RAM_W : (d ? dly : INF));
        berr_k = WD_EN ? T_OUT : INF;
        term_ack = (ack_k <= berr_k);
        term_k   = term_ack ? ack_k : berr_k;
        a = abort_a;
        if (term_k >= INF && a >= INF) a = 90;
        aborted = (a <= term_k);
        end_k   = aborted ? a : term_k + hold;

        as = 1'b0; rom_sel = r; ram_sel = m; duart_sel = d; duart_dtack = 1'b1;
        step;
        chk3($sformatf("%s.k0", tag), 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= end_k; k++) begin
            as        = (k >= end_k);
            rom_sel   = ($urandom_range(0, 1) != 0);
            ram_sel   = ($urandom_range(0, 1) != 0);
            duart_sel = ($urandom_range(0, 1) != 0);
            duart_dtack = is_duart ? !(k >= dly) : ($urandom_range(0, 1) != 0);
            step;
            e_d = !(term_ack  && !aborted && k >= term_k && k < end_k);
            e_b = !(!term_ack && !aborted && k >= term_k && k < end_k);
            chk3($sformatf("%s.k%0d", tag, k), e_d, e_b, k < end_k);
        end
        as = 1'b1; rom_sel = 1'b0; ram_sel = 1'b0; duart_sel = 1'b0; duart_dtack = 1'b1;
    endtask

    initial begin
        reset = 1'b0; as = 1'b1; rom_sel = 1'b0; ram_sel = 1'b0; duart_sel = 1'b0; duart_dtack = 1'b1;
        step;
        step;
        chk3("reset", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        idle(1, "post_reset");

        run_cycle(1'b0, 1'b1, 1'b0, INF, INF, 2, "ram");
        run_cycle(1'b1, 1'b0, 1'b0, INF, INF, 1, "rom");
        idle(1, "gap_a");
        run_cycle(1'b1, 1'b1, 1'b0, INF, INF, 3, "rom_ram");
        run_cycle(1'b0, 1'b0, 1'b1, 10, INF, 4, "duart10");
        run_cycle(1'b0, 1'b0, 1'b1, INF, INF, 2, "duart_none");
        run_cycle(1'b0, 1'b0, 1'b0, INF, WD_EN ? INF : 200, 2, "nosel");
        run_cycle(1'b0, 1'b0, 1'b1, T_OUT, INF, 2, "coincide");
        run_cycle(1'b1, 1'b0, 1'b0, INF, 1, 1, "rom_abort");
        run_cycle(1'b0, 1'b1, 1'b0, INF, INF, 1, "ram_after_abort");

        // Reset while the RAM cycle sits in its acknowledge phase
        as = 1'b0; ram_sel = 1'b1;
        step;
        chk3("mid.start", 1'b1, 1'b1, 1'b1);
        ram_sel = 1'b0;
        step;
        chk3("mid.ack", 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        step;
        chk3("mid.reset", 1'b1, 1'b1, 1'b0);
        reset = 1'b1; as = 1'b1;
        step;
        chk3("mid.release", 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, INF, INF, 2, "ram_after_reset");

        for (int i = 0; i < 40; i++) begin
            logic r, m, d;
            int dly, ab;
            r   = ($urandom_range(0, 3) == 0);
            m   = ($urandom_range(0, 2) == 0);
            d   = ($urandom_range(0, 1) != 0);
            dly = ($urandom_range(0, 4) == 0) ? INF : $urandom_range(1, 70);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : INF;
            run_cycle(r, m, d, dly, ab, $urandom_range(1, 4), $sformatf("rnd%0d", i));
            idle($urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Synchronous 68000 bus-cycle terminator for the CPLD glue logic.
- Sits directly downstream of the address/chip-select decoder. It consumes the decoded select strobes plus /AS and the DUART's own /DTACK.
- Generates the CPU's /DTACK with per-device wait states.
- Generates /BERR via a watchdog when no device answers.

Parameters:
- ROM_WAIT, 2: wait states inserted before /DTACK for ROM cycles.
- RAM_WAIT, 0: wait states inserted before /DTACK for RAM cycles.
- BERR_TIMEOUT, 64: clocks from cycle start to /BERR when unterminated. Legal range 4..127.
- CNT_W, 7: width of the wait and watchdog counters. Must hold BERR_TIMEOUT-1.

Ports:
- clk_in, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- as, input, 1: CPU /AS, active low. Pre-synchronised upstream.
- rom_sel, input, 1: decoder ROM select, active high. Valid while as=0.
- ram_sel, input, 1: decoder RAM select, active high.
- duart_sel, input, 1: decoder DUART select, active high.
- duart_dtack, input, 1: 68681 /DTACK, active low.
- dtack, output, 1: CPU /DTACK, active low, registered.
- berr, output, 1: CPU /BERR, active low, registered.
- busy, output, 1: high while a cycle is in progress (state != IDLE), registered.

Behaviour:
- Clock and reset: one clock (clk_in). Synchronous active-low reset: when reset=0 at a rising edge the block goes to state IDLE with dtack=1, berr=1, busy=0 and both counters cleared. Reset overrides everything, including mid-cycle.
- States: IDLE, WAIT, DUART, NOSEL, ACK, BERR.
- Cycle start, IDLE with as=0 sampled at edge N. Select priority is rom_sel > ram_sel > duart_sel; multiple selects are a decoder fault and priority applies.
  - rom_sel: go to WAIT, load cnt=ROM_WAIT.
  - ram_sel: go to WAIT, load cnt=RAM_WAIT.
  - duart_sel: go to DUART.
  - No select: go to NOSEL.
  - In all four cases set wd=0 and busy=1.
- WAIT: at each edge, if cnt==0 go to ACK (dtack=0 from that edge); otherwise decrement cnt.
  - Latency: dtack falls after edge N+1+W, where W is the loaded wait value.
  - RAM_WAIT=0 gives dtack low after edge N+1; ROM_WAIT=2 gives N+3.
- DUART: duart_dtack=0 sampled at an edge sends the block to ACK, so dtack falls one clock after the DUART answers.
- NOSEL: waits only for the watchdog.
- Watchdog (WAIT, DUART, NOSEL): at each edge, if wd==BERR_TIMEOUT-1 go to BERR (berr=0); otherwise increment wd.
  - berr falls after edge N+BERR_TIMEOUT.
  - If an ack condition and the timeout coincide on the same edge, ack wins: go to ACK, berr stays 1.
- ACK and BERR: outputs are held until as=1 is sampled. On that edge go to IDLE with dtack=1, berr=1, busy=0. dtack and berr are never both 0.
- Early /AS release: as=1 sampled in WAIT, DUART or NOSEL aborts the cycle. Go to IDLE with outputs inactive; no late dtack or berr is issued.
- Back-to-back cycles: as stays 1 for at least one sampled edge between cycles. A new cycle is recognised only from IDLE, so the earliest restart is the edge after returning to IDLE.
- Select inputs are sampled only on the IDLE→start edge. Later changes are ignored until the next cycle.

Optional Feature:
- Macro: BUS_WATCHDOG_EN.
- Defined: watchdog and BERR state behave as described above.
- Undefined:
  - wd counter and BERR state are not built; berr is tied to 1.
  - An unselected or unanswered cycle stays in NOSEL/DUART until as returns high, then goes to IDLE.
  - ROM/RAM/DUART timing is unchanged.

Test Plan:
- RAM read: reset=0 for 2 clocks then 1; as=0 with ram_sel=1 at edge N → dtack=0 after N+1, berr=1. as=1 → dtack=1 on the next edge, busy=0.
- ROM with ROM_WAIT=2: as=0 with rom_sel=1 at edge N → dtack stays 1 through N+2 and falls after N+3. Also assert rom_sel and ram_sel together → ROM timing (N+3) is used.
- DUART: duart_sel=1, duart_dtack driven 0 at edge N+10 → dtack=0 after N+10 and held until as=1. With duart_dtack held 1 and BERR_TIMEOUT=64 → berr=0 after N+64, dtack=1.
- Unmapped address: no selects at edge N → berr=0 after N+64. Without BUS_WATCHDOG_EN → berr stays 1 for 200 clocks; as=1 returns busy to 0.
- Coincidence and abort:
  - duart_dtack=0 sampled exactly at edge N+64 → dtack=0, berr=1.
  - Separately, as=1 at N+1 in ROM WAIT → IDLE, no dtack pulse.
- Reset mid-cycle: reset=0 while in ACK → next edge gives dtack=1, berr=1, busy=0. A fresh RAM cycle afterwards responds at N+1.
